// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment bit order, blank/dash codes,
// glyph encoder and the converter state type.
package seg7_pkg;

  // seg_n bit order is {A,B,C,D,E,F,G}: A in bit 6, G in bit 0, active low.
  localparam int SEG_A = 6;
  localparam int SEG_G = 0;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  typedef enum logic {
    CONV_IDLE  = 1'b0,
    CONV_SHIFT = 1'b1
  } conv_state_t;

  // Active-low glyph for one nibble: 0-9 then A,b,C,d,E,F.
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0000100;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b1100000;
      4'hC: g = 7'b0110001;
      4'hD: g = 7'b1000010;
      4'hE: g = 7'b0110000;
      default: g = 7'b0111000;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: one add-3/shift step per clock, 4*N_DIGITS steps.
// Result and overflow are presented combinationally alongside the done pulse
// so the consumer can capture them on the same edge that busy falls.
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int N_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*N_DIGITS-1:0] bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*N_DIGITS-1:0] bcd,
  output logic                  overflow
);
  localparam int BIN_W = 4*N_DIGITS;
  // Two spare digits cover every binary value of BIN_W bits (N_DIGITS <= 8).
  localparam int BCD_D = N_DIGITS + 2;
  localparam int BCD_W = 4*BCD_D;
  localparam int CNT_W = $clog2(BIN_W + 1);

  conv_state_t      state, state_nx;
  logic [BIN_W-1:0] sh_bin;
  logic [BCD_W-1:0] sh_bcd, adj_bcd, nxt_bcd;
  logic [CNT_W-1:0] cnt;

  // Add-3 correction on every digit >= 5, then shift in the next binary bit.
  always_comb begin
    adj_bcd = sh_bcd;
    for (int d = 0; d < BCD_D; d++)
      if (sh_bcd[4*d +: 4] >= 4'd5) adj_bcd[4*d +: 4] = sh_bcd[4*d +: 4] + 4'd3;
    nxt_bcd = {adj_bcd[BCD_W-2:0], sh_bin[BIN_W-1]};
  end

  assign bcd      = nxt_bcd[BIN_W-1:0];
  assign overflow = (|nxt_bcd[BCD_W-1:BIN_W]) | adj_bcd[BCD_W-1];

  // State register and shift datapath; reset aborts any conversion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= CONV_IDLE;
      cnt    <= '0;
      sh_bin <= '0;
      sh_bcd <= '0;
    end else begin
      state <= state_nx;
      if (state == CONV_IDLE && start) begin
        sh_bin <= bin;
        sh_bcd <= '0;
        cnt    <= CNT_W'(BIN_W);
      end else if (state == CONV_SHIFT) begin
        sh_bin <= {sh_bin[BIN_W-2:0], 1'b0};
        sh_bcd <= nxt_bcd;
        cnt    <= cnt - 1'b1;
      end
    end
  end

  // Next state and status decode; start is only honoured when idle.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      CONV_IDLE:  if (start) state_nx = CONV_SHIFT;
      CONV_SHIFT: begin
        busy = 1'b1;
        if (cnt == CNT_W'(1)) begin
          done     = 1'b1;
          state_nx = CONV_IDLE;
        end
      end
      default:    state_nx = CONV_IDLE;
    endcase
  end

endmodule

// File: rtl/multi_7seg_scan.sv
// Multiplexed N-digit seven-segment driver: display register, digit scan with
// dead time, PWM brightness, leading-zero blanking, registered outputs.
module multi_7seg_scan
  import seg7_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int HEX_MODE = 1,
  parameter int SCAN_DIV = 1000,
  parameter int BRIGHT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic                  load,
  output logic                  busy,
  input  logic                  colon_en,
  input  logic                  blank_lz,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [6:0]            seg_n,
  output logic [N_DIGITS-1:0]   digit_en,
  output logic                  colon,
  output logic                  overflow
);
  localparam int VAL_W = 4*N_DIGITS;
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [VAL_W-1:0]    disp;
  logic                ovf;
  logic [PRE_W-1:0]    presc;
  logic [IDX_W-1:0]    idx;
  logic [BRIGHT_W-1:0] pwm;
  logic                cap_en, cap_ovf, conv_busy;
  logic [VAL_W-1:0]    cap_val;
  logic [N_DIGITS-1:0] blank;
  logic                lz_run, lit;
  logic [3:0]          cur_nib;

  // Hex mode takes the raw value directly; decimal mode goes through the converter.
  generate
    if (HEX_MODE != 0) begin : g_hex
      assign conv_busy = 1'b0;
      assign cap_en    = load;
      assign cap_val   = value;
      assign cap_ovf   = 1'b0;
    end else begin : g_dec
      bin2bcd_seq #(.N_DIGITS(N_DIGITS)) u_b2b (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (load),
        .bin      (value),
        .busy     (conv_busy),
        .done     (cap_en),
        .bcd      (cap_val),
        .overflow (cap_ovf)
      );
    end
  endgenerate

  assign busy     = conv_busy;
  assign overflow = ovf;

  // Display register and overflow flag update together on a completed capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp <= '0;
      ovf  <= 1'b0;
    end else if (cap_en) begin
      disp <= cap_val;
      ovf  <= cap_ovf;
    end
  end

  // Scan prescaler, digit index and free-running PWM counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
      pwm   <= '0;
    end else begin
      pwm <= pwm + 1'b1;
      if (presc == PRE_W'(SCAN_DIV - 1)) begin
        presc <= '0;
        idx   <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  // Blank digit i (i > 0) when it and every digit above it are zero.
  always_comb begin
    lz_run = 1'b1;
    blank  = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      lz_run = lz_run && (disp[4*i +: 4] == 4'd0);
      if (i != 0) blank[i] = blank_lz && !ovf && lz_run;
    end
  end

  // Slot is lit outside the dead-time cycle and inside the PWM duty window.
  assign lit     = (presc != '0) && ((&brightness) || (pwm < brightness));
  assign cur_nib = disp[{idx, 2'b00} +: 4];

  // Output registers: one enable, matching glyph, colon gated like the digit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_n    <= SEG_BLANK;
      digit_en <= '0;
      colon    <= 1'b0;
    end else begin
      seg_n    <= SEG_BLANK;
      digit_en <= '0;
      colon    <= 1'b0;
      if (lit) begin
        digit_en <= N_DIGITS'(1) << idx;
        colon    <= colon_en;
        if (ovf)              seg_n <= SEG_DASH;
        else if (!blank[idx]) seg_n <= glyph(cur_nib);
      end
    end
  end

endmodule

// File: tb/tb_multi_7seg_scan.sv
// Bench: hex and decimal instances side by side, checked every cycle against
// an arithmetic model (scan position from a cycle count, digits by div/mod).
module tb_multi_7seg_scan;
  localparam int N  = 4;
  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst_n, load, colon_en, blank_lz;
  logic [15:0] value;
  logic [3:0]  brightness;
  logic        h_busy, h_colon, h_ovf, d_busy, d_colon, d_ovf;
  logic [6:0]  h_seg, d_seg;
  logic [3:0]  h_en, d_en;

  always #5 clk = ~clk;

  multi_7seg_scan #(.N_DIGITS(N), .HEX_MODE(1), .SCAN_DIV(SD), .BRIGHT_W(4)) u_hex (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .busy(h_busy),
    .colon_en(colon_en), .blank_lz(blank_lz), .brightness(brightness),
    .seg_n(h_seg), .digit_en(h_en), .colon(h_colon), .overflow(h_ovf));

  multi_7seg_scan #(.N_DIGITS(N), .HEX_MODE(0), .SCAN_DIV(SD), .BRIGHT_W(4)) u_dec (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .busy(d_busy),
    .colon_en(colon_en), .blank_lz(blank_lz), .brightness(brightness),
    .seg_n(d_seg), .digit_en(d_en), .colon(d_colon), .overflow(d_ovf));

  int vectors = 0, miscompares = 0;

  // model state: [0] hex instance, [1] decimal instance
  int k;
  int m_disp [2];
  int m_ovf  [2];
  int m_busy, m_cnt, m_pend;

  // active-high {A..G} segments for 0-9,A,b,C,d,E,F
  logic [6:0] seg_on [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                              7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  function automatic int ipow(input int b, input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h (k=%0d)", tag, obs, exp, k);
    end
  endtask

  // One clock: predict outputs, advance the model on the edge, compare at negedge.
  task automatic cycle();
    logic [6:0] e_seg [2];
    logic [3:0] e_en;
    logic       e_col;
    int         idx, dig, base;
    bit         lit, blk;
    if (!rst_n) begin
      e_en = 4'h0; e_col = 1'b0; e_seg = '{7'h7F, 7'h7F};
    end else begin
      idx   = (k / SD) % N;
      lit   = (k % SD != 0) && (brightness == 4'hF || (k % 16) < int'(brightness));
      e_en  = lit ? 4'(1 << idx) : 4'h0;
      e_col = lit && colon_en;
      for (int m = 0; m < 2; m++) begin
        base = (m == 0) ? 16 : 10;
        dig  = (m_disp[m] / ipow(base, idx)) % base;
        blk  = blank_lz && idx > 0 && m_disp[m] < ipow(base, idx);
        if (!lit)          e_seg[m] = 7'h7F;
        else if (m_ovf[m] != 0) e_seg[m] = 7'h7E;
        else if (blk)      e_seg[m] = 7'h7F;
        else               e_seg[m] = ~seg_on[dig];
      end
    end
    @(posedge clk);
    if (!rst_n) begin
      k = 0; m_disp = '{0, 0}; m_ovf = '{0, 0}; m_busy = 0; m_cnt = 0;
    end else begin
      k++;
      if (load) m_disp[0] = int'(value);
      if (m_busy != 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 0; m_disp[1] = m_pend; m_ovf[1] = (m_pend > 9999) ? 1 : 0;
        end
      end else if (load) begin
        m_pend = int'(value); m_cnt = 16; m_busy = 1;
      end
    end
    @(negedge clk);
    check("hex_seg_n",    32'(h_seg),   32'(e_seg[0]));
    check("hex_digit_en", 32'(h_en),    32'(e_en));
    check("hex_colon",    32'(h_colon), 32'(e_col));
    check("hex_busy",     32'(h_busy),  32'(0));
    check("hex_overflow", 32'(h_ovf),   32'(m_ovf[0]));
    check("dec_seg_n",    32'(d_seg),   32'(e_seg[1]));
    check("dec_digit_en", 32'(d_en),    32'(e_en));
    check("dec_colon",    32'(d_colon), 32'(e_col));
    check("dec_busy",     32'(d_busy),  32'(m_busy));
    check("dec_overflow", 32'(d_ovf),   32'(m_ovf[1]));
  endtask

  initial begin
    k = 0; m_disp = '{0, 0}; m_ovf = '{0, 0}; m_busy = 0; m_cnt = 0; m_pend = 0;
    rst_n = 1'b0; load = 1'b1; value = 16'h1234;
    colon_en = 1'b1; blank_lz = 1'b0; brightness = 4'hF;
    // load held during reset must be ignored
    repeat (3) cycle();
    rst_n = 1'b1; load = 1'b0;
    repeat (6) cycle();
    // hex BEEF at full brightness (decimal instance overflows on it)
    value = 16'hBEEF; load = 1'b1; cycle(); load = 1'b0;
    repeat (40) cycle();
    // decimal 1234, with 5678 offered mid-conversion
    value = 16'd1234; load = 1'b1; cycle(); load = 1'b0;
    repeat (5) cycle();
    value = 16'd5678; load = 1'b1; cycle(); load = 1'b0;
    repeat (40) cycle();
    // overflow then recovery with leading-zero blanking
    value = 16'd10000; load = 1'b1; cycle(); load = 1'b0;
    repeat (40) cycle();
    value = 16'd7; blank_lz = 1'b1; load = 1'b1; cycle(); load = 1'b0;
    repeat (40) cycle();
    // brightness extremes
    brightness = 4'd0; repeat (20) cycle();
    brightness = 4'd4; repeat (48) cycle();
    // reset in the middle of a conversion
    brightness = 4'hF; blank_lz = 1'b0;
    value = 16'd4321; load = 1'b1; cycle(); load = 1'b0;
    repeat (8) cycle();
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    repeat (40) cycle();
    // randomized traffic
    repeat (500) begin
      load       = ($urandom_range(0, 7) == 0);
      value      = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 99));
      brightness = 4'($urandom);
      colon_en   = 1'($urandom_range(0, 1));
      blank_lz   = 1'($urandom_range(0, 1));
      rst_n      = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multi_7seg_scan.md
MULTI_7SEG_SCAN -- requirements
Module: multi_7seg_scan

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter HEX_MODE, default 1; 1 = hex display, 0 = decimal display of the binary value.
REQ-003 SHALL have parameter SCAN_DIV, default 1000, clocks per digit slot (legal >= 4).
REQ-004 SHALL have parameter BRIGHT_W, default 4, brightness word width.
REQ-005 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port value  input  4*N_DIGITS  binary value to display.
REQ-008 SHALL have port load  input  1  capture strobe for value.
REQ-009 SHALL have port busy  output  1  decimal conversion in progress.
REQ-010 SHALL have port colon_en  input  1  colon request.
REQ-011 SHALL have port blank_lz  input  1  leading-zero blanking enable.
REQ-012 SHALL have port brightness  input  BRIGHT_W  PWM duty.
REQ-013 SHALL have port seg_n  output  7  segments {A,B,C,D,E,F,G}, active low.
REQ-014 SHALL have port digit_en  output  N_DIGITS  digit enables, active high, at most one set.
REQ-015 SHALL have port colon  output  1  colon anode, active high.
REQ-016 SHALL have port overflow  output  1  decimal value exceeds 10^N_DIGITS-1.

Function
REQ-017 load accepted only when busy=0; load while busy=1 SHALL be ignored.
REQ-018 HEX_MODE=1: accepted value SHALL reach display register next cycle; busy stays 0; digit i shows nibble i.
REQ-019 HEX_MODE=0: busy SHALL rise the cycle after accept, stay high exactly 4*N_DIGITS cycles (one double-dabble shift per cycle), display register and overflow update on busy's falling cycle.
REQ-020 Overflow (value >= 10^N_DIGITS) SHALL set overflow=1 and show dash (G only, seg_n=7'b1111110) on every digit; next in-range accept clears it.
REQ-021 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; on wrap digit index SHALL advance 0..N_DIGITS-1 and wrap to 0.
REQ-022 Dead time: digit_en SHALL be all zero while prescaler==0 (anti-ghosting).
REQ-023 Free-running BRIGHT_W-bit PWM counter; digit enabled iff pwm<brightness, or brightness all-ones (always on); brightness=0 SHALL keep digit_en=0.
REQ-024 When digit_en is all zero, seg_n SHALL be all ones and colon 0.
REQ-025 blank_lz=1: digits above the most significant nonzero digit SHALL show seg_n all ones; digit 0 always shown; no effect when overflow=1.
REQ-026 colon SHALL equal colon_en gated by same enable condition as digit_en.
REQ-027 Glyphs: standard 0-9, A,b,C,d,E,F; decimal digits use 0-9 only.
REQ-028 All outputs SHALL be registered; output reflects internal state one cycle later.
REQ-029 Inputs brightness, colon_en, blank_lz SHALL take effect within 2 cycles, no capture.

Reset
REQ-030 rst_n=0 at clk edge SHALL give: seg_n all ones, digit_en 0, colon 0, busy 0, overflow 0, display register 0, prescaler 0, index 0, PWM counter 0.
REQ-031 Reset during conversion SHALL abort it; no partial result reaches display.
REQ-032 load during reset SHALL be ignored.

Structure
REQ-033 Package seg7_pkg SHALL hold glyph encoding function, blank/dash constants, segment bit order.
REQ-034 Sub-module bin2bcd_seq SHALL implement the iterative double-dabble with start/busy/done and overflow flag; instantiated only when HEX_MODE=0.
REQ-035 Scan, PWM, blanking and output registers SHALL live in multi_7seg_scan.

Verification (N_DIGITS=4, SCAN_DIV=4, BRIGHT_W=4)
REQ-036 Hex: load 16'hBEEF, brightness 4'hF -> digit_en cycles 0001,0010,0100,1000 with seg_n glyphs F,E,E,b; zero enables on every prescaler==0 cycle.
REQ-037 Decimal: load 16'd1234 -> busy high 16 cycles, then digits 4,3,2,1; load 16'd5678 mid-conversion ignored.
REQ-038 Decimal overflow: load 16'd10000 -> overflow=1, all digits dash; then load 16'd7 -> overflow=0, blank_lz=1 shows digits 3..1 blank, digit 0 = 7.
REQ-039 Brightness 4'd0 -> digit_en=0, seg_n=7'h7F, colon 0; brightness 4'd4 -> enable duty 4/16 within active slot cycles.
REQ-040 Reset asserted at busy cycle 8 -> all REQ-030 values next cycle; display shows 0000 after release.
